// File: rtl/pci_bus_arbiter_if.sv
// Shared PCI arbitration signals between the bus masters and the central arbiter.
// master: the requesting side; slave: the arbiter that answers with grants.
interface pci_bus_arbiter_if;
    logic [2:0] REQn;
    logic       FRAMEn;
    logic       IRDYn;
    logic [2:0] GNTn;
    logic [1:0] OWNER;
    logic       BUS_IDLE;

    modport master (
        output REQn, FRAMEn, IRDYn,
        input  GNTn, OWNER, BUS_IDLE
    );

    modport slave (
        input  REQn, FRAMEn, IRDYn,
        output GNTn, OWNER, BUS_IDLE
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Three-master round-robin PCI bus arbiter with grant timeout and one-cycle turnaround.
// Optional bus parking on the last owner is enabled by defining ARB_PARK_EN.
module pci_bus_arbiter #(
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    pci_bus_arbiter_if.slave bus,
    output logic [1:0]       state_dbg
);
`ifdef ARB_PARK_EN
    localparam bit PARK_EN = 1'b1;
`else
    localparam bit PARK_EN = 1'b0;
`endif

    localparam logic [7:0] TMO_LAST = 8'(GRANT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANTED    = 2'd1,
        BUSY       = 2'd2,
        TURNAROUND = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] gnt_n;
    logic [1:0] owner;
    logic [1:0] last_owner;
    logic [1:0] park_idx;
    logic       bus_idle;
    logic [7:0] tmo_cnt;

    logic [3:0] req;
    logic [2:0] own_mask;
    logic       any_req;
    logic       others_req;
    logic       parked;
    logic [1:0] start;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] winner;

    // Handshake: a master requests by holding REQn[i] low; it may drive FRAMEn only
    // while GNTn[i] is low and BUS_IDLE is high. Requests are levels, so any request
    // seen outside IDLE simply stays pending until the arbiter is back in IDLE.
    always_comb begin
        req        = {1'b0, ~bus.REQn};
        own_mask   = 3'b001 << owner;
        any_req    = |req[2:0];
        others_req = |(req[2:0] & ~own_mask);
        parked     = PARK_EN && (state == IDLE) && (gnt_n != 3'b111);
        start      = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
        cand1      = (start == 2'd2) ? 2'd0 : start + 2'd1;
        cand2      = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
        if (req[start])      winner = start;
        else if (req[cand1]) winner = cand1;
        else                 winner = cand2;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            gnt_n      <= 3'b111;
            owner      <= 2'b11;
            last_owner <= 2'd2;
            park_idx   <= 2'd0;
            bus_idle   <= 1'b1;
            tmo_cnt    <= 8'd0;
        end else begin
            bus_idle <= bus.FRAMEn & bus.IRDYn;
            case (state)
                IDLE: begin
                    if (parked) begin
                        // A parked master may start a transaction without re-arbitrating.
                        if (!bus.FRAMEn && bus_idle) begin
                            state <= BUSY;
                        end else if (others_req) begin
                            gnt_n <= 3'b111;
                            owner <= 2'b11;
                            state <= TURNAROUND;
                        end else if (any_req) begin
                            tmo_cnt <= 8'd0;
                            state   <= GRANTED;
                        end
                    end else if (any_req) begin
                        gnt_n   <= ~(3'b001 << winner);
                        owner   <= winner;
                        tmo_cnt <= 8'd0;
                        state   <= GRANTED;
                    end else if (PARK_EN) begin
                        gnt_n <= ~(3'b001 << park_idx);
                        owner <= park_idx;
                    end
                end
                GRANTED: begin
                    // FRAMEn wins over a simultaneous release of the request.
                    if (!bus.FRAMEn && bus_idle) begin
                        state <= BUSY;
                    end else if (!req[owner] || tmo_cnt == TMO_LAST) begin
                        gnt_n      <= 3'b111;
                        last_owner <= owner;
                        park_idx   <= owner;
                        owner      <= 2'b11;
                        state      <= TURNAROUND;
                    end else if (bus_idle && bus.FRAMEn && tmo_cnt != 8'hFF) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                BUSY: begin
                    if (bus.FRAMEn && bus.IRDYn) begin
                        gnt_n      <= 3'b111;
                        last_owner <= owner;
                        park_idx   <= owner;
                        owner      <= 2'b11;
                        state      <= TURNAROUND;
                    end else if (others_req) begin
                        // Owner keeps the bus only for the transaction already in flight.
                        gnt_n <= 3'b111;
                    end
                end
                TURNAROUND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.GNTn     = gnt_n;
    assign bus.OWNER    = owner;
    assign bus.BUS_IDLE = bus_idle;
    assign state_dbg    = state;
endmodule

// File: doc/pci_bus_arbiter.md
PCI_BUS_ARBITER -- requirements
Module: pci_bus_arbiter

Interface
REQ-001 Parameter GRANT_TIMEOUT, default 16: number of idle-bus cycles a granted master has to assert FRAMEn before its grant is revoked (legal range 2..255).
REQ-002 CLK  input  1  bus clock; all state updates on the rising edge.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 REQn  input  3  per-master bus request, active-low; bit i belongs to master i.
REQ-005 FRAMEn  input  1  shared PCI FRAME#, active-low, sampled on the rising edge of CLK.
REQ-006 IRDYn  input  1  shared PCI IRDY#, active-low, sampled on the rising edge of CLK.
REQ-007 GNTn  output  3  per-master grant, active-low, registered; at most one bit low at any time.
REQ-008 OWNER  output  2  index of the master currently granted or owning the bus; 2'b11 when no master is granted.
REQ-009 BUS_IDLE  output  1  registered flag, high when FRAMEn and IRDYn were both sampled high on the previous edge.

Function
REQ-010 The arbiter SHALL implement four states: IDLE, GRANTED, BUSY and TURNAROUND.
REQ-011 IDLE: if any REQn bit is low, the arbiter SHALL assert GNTn of the winning master on the next edge and move to GRANTED.
REQ-012 Winner selection SHALL be round-robin: the search starts at index (last_owner+1) mod 3 and wraps 2->0.
REQ-013 GRANTED: when FRAMEn is sampled low while BUS_IDLE is high, the arbiter SHALL move to BUSY; the grant holder is the owner.
REQ-014 GRANTED: when the granted master releases REQn before FRAMEn is asserted, the arbiter SHALL deassert GNTn and move to TURNAROUND.
REQ-015 GRANTED: a timeout counter SHALL count cycles with the bus idle and FRAMEn high. On reaching GRANT_TIMEOUT-1 the arbiter SHALL deassert GNTn, record the master as last_owner and move to TURNAROUND.
REQ-016 BUSY: if any other master's REQn is low, the owner's GNTn SHALL be deasserted on the next edge, so the owner completes only the current transaction. Otherwise GNTn SHALL stay asserted.
REQ-017 BUSY: when FRAMEn and IRDYn are both sampled high, the arbiter SHALL record last_owner and move to TURNAROUND.
REQ-018 TURNAROUND SHALL last exactly one cycle with all GNTn high, then return to IDLE. Two different masters SHALL never be granted on consecutive edges.
REQ-019 Requests arriving in any state other than IDLE SHALL be held pending, not dropped; they are evaluated on the next entry to IDLE.
REQ-020 Simultaneous release of REQn and assertion of FRAMEn in GRANTED: FRAMEn SHALL take priority and the arbiter SHALL move to BUSY.
REQ-021 FRAMEn asserted by the bus while in IDLE or TURNAROUND SHALL be ignored; no grant changes.
REQ-022 The timeout counter SHALL be 8 bits, cleared on every entry to GRANTED, and SHALL saturate rather than wrap.

Reset
REQ-023 While RSTn is low: GNTn=3'b111, OWNER=2'b11, BUS_IDLE=1, state=IDLE, last_owner=2, timeout counter=0. The first grant after reset therefore goes to the lowest requesting index, starting the search at master 0.
REQ-024 Reset asserted mid-transaction SHALL immediately deassert all GNTn, without waiting for a clock edge.

Configuration
REQ-025 Macro ARB_PARK_EN. When defined and no REQn is low in IDLE, the arbiter SHALL park: it asserts GNTn of last_owner (master 0 after reset) and OWNER shows that index.
REQ-026 With ARB_PARK_EN defined, FRAMEn sampled low from the parked master SHALL move the arbiter directly to BUSY. Any request from another master SHALL remove the park grant, pass through TURNAROUND, and then follow REQ-011.
REQ-027 Without ARB_PARK_EN, all GNTn SHALL be high whenever no master is granted.

Verification
REQ-028 Reset release, REQn=3'b110 -> GNTn=3'b110 one edge later, OWNER=0.
REQ-029 REQn=3'b000 held, each master runs one 4-cycle FRAMEn transaction -> grants go 0,1,2,0, each separated by one TURNAROUND cycle with GNTn=3'b111.
REQ-030 Master 1 granted, FRAMEn never asserted, GRANT_TIMEOUT=16 -> GNTn[1] rises after 16 idle cycles; master 2's request is granted 2 cycles later.
REQ-031 Master 0 in BUSY, REQn[2] falls -> GNTn[0] rises on the next edge; GNTn[2] falls only after the bus is idle plus one TURNAROUND cycle.
REQ-032 With ARB_PARK_EN: no requests after master 2 finishes -> GNTn=3'b011 persists. Without ARB_PARK_EN: GNTn=3'b111.
REQ-033 RSTn pulsed low mid-BUSY -> GNTn=3'b111 and OWNER=3 within the same cycle.
